// File: rtl/alu_exec_pkg.sv
// Shared op, encoding and FSM types for the execute-stage ALU.
package alu_exec_pkg;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_ILLEGAL
  } alu_op_e;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b01;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b10;
  localparam logic [1:0] ALUOP_BRANCH = 2'b11;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX, S_DONE} state_e;

  function automatic alu_op_e base_op(input logic [2:0] f3);
    alu_op_e op;
    case (f3)
      3'b000:  op = OP_ADD;
      3'b001:  op = OP_SLL;
      3'b010:  op = OP_SLT;
      3'b011:  op = OP_SLTU;
      3'b100:  op = OP_XOR;
      3'b101:  op = OP_SRL;
      3'b110:  op = OP_OR;
      default: op = OP_AND;
    endcase
    return op;
  endfunction

  function automatic alu_op_e muldiv_op(input logic [2:0] f3);
    alu_op_e op;
    case (f3)
      3'b000:  op = OP_MUL;
      3'b001:  op = OP_MULH;
      3'b010:  op = OP_MULHSU;
      3'b011:  op = OP_MULHU;
      3'b100:  op = OP_DIV;
      3'b101:  op = OP_DIVU;
      3'b110:  op = OP_REM;
      default: op = OP_REMU;
    endcase
    return op;
  endfunction

  function automatic logic is_div_op(input alu_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALUOp/funct3/funct7 decode. M ops decode only when RV_M_EXT_EN is defined.
module alu_op_decode
  import alu_exec_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output alu_op_e    op,
  output logic       is_multicycle
);

  always_comb begin
    op            = OP_ILLEGAL;
    is_multicycle = 1'b0;
    case (alu_op)
      ALUOP_ADD:    op = OP_ADD;
      ALUOP_BRANCH: op = OP_SUB;
      ALUOP_RTYPE: begin
        case (funct7)
          F7_BASE: op = base_op(funct3);
          F7_ALT: begin
            if (funct3 == 3'b000)      op = OP_SUB;
            else if (funct3 == 3'b101) op = OP_SRA;
          end
`ifdef RV_M_EXT_EN
          F7_MULDIV: begin
            op            = muldiv_op(funct3);
            is_multicycle = 1'b1;
          end
`else
          F7_MULDIV: op = OP_ILLEGAL;
`endif
          default: op = OP_ILLEGAL;
        endcase
      end
      default: begin
        // Immediate forms: funct7 only matters for the shift encodings.
        if (funct3 == 3'b001)      op = (funct7 == F7_BASE) ? OP_SLL : OP_ILLEGAL;
        else if (funct3 == 3'b101) op = funct7[5] ? OP_SRA : OP_SRL;
        else                       op = base_op(funct3);
      end
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshake; optional iterative mul/div
// datapath enabled by RV_M_EXT_EN.
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  state_e          state_q, state_d;
  alu_op_e         dec_op;
  logic            dec_multi;
  logic            accept;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] result_q;
  logic            zero_q, illegal_q;
  logic [SHAMT_W-1:0] shamt;

  alu_op_decode u_decode (
    .alu_op       (alu_op),
    .funct3       (funct3),
    .funct7       (funct7),
    .op           (dec_op),
    .is_multicycle(dec_multi)
  );

  assign shamt = b[SHAMT_W-1:0];

  always_comb begin
    alu_res = '0;
    case (dec_op)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SLL:  alu_res = a << shamt;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = $signed(a) >>> shamt;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, a < b};
      default: alu_res = '0;
    endcase
  end

`ifdef RV_M_EXT_EN
  localparam int unsigned CNT_W = $clog2(XLEN) + 1;

  // acc_q low half holds multiplier/dividend, high half partial product/remainder.
  logic [2*XLEN-1:0] acc_q, acc_step, prod;
  logic [XLEN-1:0]   opnd_q, a_mag, b_mag, quo, rem, fix_res;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [CNT_W-1:0]  cnt_q;
  alu_op_e           op_q;
  logic              q_neg_q, r_neg_q, b_zero_q;
  logic              a_neg, b_neg, div_ge;

  always_comb begin
    a_neg = (dec_op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && a[XLEN-1];
    b_neg = (dec_op inside {OP_MULH, OP_DIV, OP_REM}) && b[XLEN-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;

    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_ge    = div_shift >= {1'b0, opnd_q};
    if (is_div_op(op_q))
      acc_step = {div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0], acc_q[XLEN-2:0], div_ge};
    else
      acc_step = {mul_sum, acc_q[XLEN-1:1]};

    prod = q_neg_q ? -acc_q : acc_q;
    quo  = b_zero_q ? '1 : (q_neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0]);
    rem  = r_neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:                       fix_res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fix_res = quo;
      default:                      fix_res = rem;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      op_q     <= OP_ADD;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      b_zero_q <= 1'b0;
    end else if (accept && dec_multi) begin
      acc_q    <= {{XLEN{1'b0}}, is_div_op(dec_op) ? a_mag : b_mag};
      opnd_q   <= is_div_op(dec_op) ? b_mag : a_mag;
      cnt_q    <= '0;
      op_q     <= dec_op;
      q_neg_q  <= a_neg ^ b_neg;
      r_neg_q  <= a_neg;
      b_zero_q <= (b == '0);
    end else if (state_q == S_BUSY) begin
      acc_q <= acc_step;
      cnt_q <= cnt_q + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    accept   = in_valid && in_ready && !flush;
    case (state_q)
      S_IDLE: if (accept) state_d = dec_multi ? S_BUSY : S_DONE;
`ifdef RV_M_EXT_EN
      S_BUSY: if (cnt_q == CNT_W'(XLEN - 1)) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
`endif
      S_DONE: if (out_ready) state_d = accept ? (dec_multi ? S_BUSY : S_DONE) : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else if (accept && !dec_multi) begin
      result_q  <= alu_res;
      zero_q    <= (alu_res == '0);
      illegal_q <= (dec_op == OP_ILLEGAL);
    end
`ifdef RV_M_EXT_EN
    else if (state_q == S_FIX) begin
      result_q  <= fix_res;
      zero_q    <= (fix_res == '0);
      illegal_q <= 1'b0;
    end
`endif
  end

  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit; M-op vectors apply when RV_M_EXT_EN is defined.
module tb_alu_exec_unit;

  localparam int unsigned XLEN  = 32;
  localparam int          M_LAT = XLEN + 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [1:0]      alu_op = '0;
  logic [2:0]      funct3 = '0;
  logic [6:0]      funct7 = '0;
  logic [XLEN-1:0] a = '0;
  logic [XLEN-1:0] b = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;

  int n_checks = 0;
  int n_errors = 0;

  alu_exec_unit #(.XLEN(XLEN)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .alu_op   (alu_op),
    .funct3   (funct3),
    .funct7   (funct7),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .zero     (zero),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic start_op(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [31:0] va, input logic [31:0] vb);
    alu_op   = op;
    funct3   = f3;
    funct7   = f7;
    a        = va;
    b        = vb;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] exp_res, input logic exp_ill, input int exp_lat);
    int lat;
    start_op(op, f3, f7, va, vb);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check($sformatf("%s.lat", tag), 64'(lat), 64'(exp_lat));
    check($sformatf("%s.res", tag), result, exp_res);
    check($sformatf("%s.ill", tag), illegal, exp_ill);
    check($sformatf("%s.zero", tag), zero, exp_res == 0);
  endtask

  task automatic idle_gap();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int seen;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.valid", out_valid, 0);
    check("rst.res", result, 0);
    check("rst.zero", zero, 0);
    check("rst.ill", illegal, 0);
    check("rst.ready", in_ready, 1);
    rst_n = 1'b1;
    idle_gap();

    run_op("sub",    2'b01, 3'b000, 7'b0100000, 32'd5, 32'd7, 32'hFFFF_FFFE, 0, 1);
    run_op("srai",   2'b10, 3'b101, 7'b0100000, 32'h8000_0000, 32'h404, 32'hF800_0000, 0, 1);
    run_op("srli",   2'b10, 3'b101, 7'b0000000, 32'h8000_0000, 32'h404, 32'h0800_0000, 0, 1);
    run_op("sltu",   2'b01, 3'b011, 7'b0000000, 32'd1, 32'hFFFF_FFFF, 32'd1, 0, 1);
    run_op("slt",    2'b01, 3'b010, 7'b0000000, 32'hFFFF_FFFF, 32'd1, 32'd1, 0, 1);
    run_op("sll",    2'b01, 3'b001, 7'b0000000, 32'd1, 32'h21, 32'd2, 0, 1);
    run_op("srl",    2'b01, 3'b101, 7'b0000000, 32'h8000_0000, 32'd31, 32'd1, 0, 1);
    run_op("sra",    2'b01, 3'b101, 7'b0100000, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 0, 1);
    run_op("xor",    2'b01, 3'b100, 7'b0000000, 32'hF0F0_1234, 32'h0FF0_1234, 32'hFF00_0000, 0, 1);
    run_op("or",     2'b01, 3'b110, 7'b0000000, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 0, 1);
    run_op("and",    2'b01, 3'b111, 7'b0000000, 32'h0000_0FF0, 32'h0000_00FF, 32'h0000_00F0, 0, 1);
    run_op("ldst",   2'b00, 3'b111, 7'b1111111, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 1);
    run_op("beq",    2'b11, 3'b000, 7'b0000000, 32'd7, 32'd7, 32'd0, 0, 1);
    run_op("addi",   2'b10, 3'b000, 7'b1111111, 32'd10, 32'hFFFF_FFFF, 32'd9, 0, 1);
    run_op("ill_a",  2'b01, 3'b001, 7'b0100000, 32'd3, 32'd4, 32'd0, 1, 1);
    run_op("ill_f7", 2'b01, 3'b000, 7'b0000010, 32'd3, 32'd4, 32'd0, 1, 1);
    run_op("ill_sl", 2'b10, 3'b001, 7'b0000001, 32'd3, 32'd4, 32'd0, 1, 1);

`ifdef RV_M_EXT_EN
    run_op("mulh",   2'b01, 3'b001, 7'b0000001, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 0, M_LAT);
    run_op("mulhu",  2'b01, 3'b011, 7'b0000001, 32'hFFFF_FFFF, 32'd2, 32'd1, 0, M_LAT);
    run_op("mulhsu", 2'b01, 3'b010, 7'b0000001, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 0, M_LAT);
    run_op("mul",    2'b01, 3'b000, 7'b0000001, 32'd3, 32'hFFFF_FFFD, 32'hFFFF_FFF7, 0, M_LAT);
    run_op("div_ov", 2'b01, 3'b100, 7'b0000001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, M_LAT);
    run_op("rem_ov", 2'b01, 3'b110, 7'b0000001, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, M_LAT);
    run_op("div",    2'b01, 3'b100, 7'b0000001, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, M_LAT);
    run_op("rem",    2'b01, 3'b110, 7'b0000001, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0, M_LAT);
    run_op("div0",   2'b01, 3'b100, 7'b0000001, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 0, M_LAT);
    run_op("rem0",   2'b01, 3'b110, 7'b0000001, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 0, M_LAT);
    run_op("remu0",  2'b01, 3'b111, 7'b0000001, 32'd9, 32'd0, 32'd9, 0, M_LAT);
    run_op("divu0",  2'b01, 3'b101, 7'b0000001, 32'd9, 32'd0, 32'hFFFF_FFFF, 0, M_LAT);

    // Flush mid-MUL must suppress the result entirely.
    idle_gap();
    start_op(2'b01, 3'b000, 7'b0000001, 32'd6, 32'd7);
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("flush_mul.valid", 64'(seen), 0);
    run_op("mul_after", 2'b01, 3'b000, 7'b0000001, 32'd6, 32'd7, 32'd42, 0, M_LAT);

    // Async reset ten cycles into a DIV, with a stale nonzero result held beforehand.
    idle_gap();
    start_op(2'b01, 3'b100, 7'b0000001, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_div.valid", out_valid, 0);
    check("rst_div.res", result, 0);
    check("rst_div.zero", zero, 0);
    check("rst_div.ill", illegal, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_gap();
    run_op("divu", 2'b01, 3'b101, 7'b0000001, 32'd100, 32'd7, 32'd14, 0, M_LAT);
`else
    run_op("mul_noext", 2'b01, 3'b000, 7'b0000001, 32'd6, 32'd7, 32'd0, 1, 1);
`endif

    // Backpressure: DONE holds while out_ready is low, then back-to-back accept.
    idle_gap();
    out_ready = 1'b0;
    run_op("bp_sub", 2'b01, 3'b000, 7'b0100000, 32'd3, 32'd1, 32'd2, 0, 1);
    for (int unsigned i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp.hold_res", result, 32'd2);
      check("bp.hold_valid", out_valid, 1);
      check("bp.hold_ready", in_ready, 0);
    end
    alu_op    = 2'b00;
    a         = 32'd4;
    b         = 32'd4;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check("bp.ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp.b2b_valid", out_valid, 1);
    check("bp.b2b_res", result, 32'd8);

    // Flush of a held result, and flush overriding a same-cycle accept.
    idle_gap();
    out_ready = 1'b0;
    run_op("fl_add", 2'b00, 3'b000, 7'b0000000, 32'd1, 32'd1, 32'd2, 0, 1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_done.valid", out_valid, 0);
    check("flush_done.ready", in_ready, 1);
    alu_op   = 2'b00;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    check("flush_acc.valid0", out_valid, 0);
    @(posedge clk);
    #1;
    check("flush_acc.valid1", out_valid, 0);

    // Async reset while a result is held: outputs clear without a clock edge.
    run_op("rst_xor", 2'b01, 3'b100, 7'b0000000, 32'hF0, 32'h0F, 32'hFF, 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_hold.valid", out_valid, 0);
    check("rst_hold.res", result, 0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    idle_gap();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
